// File: rtl/wash_sequencer.sv
// Coin-operated wash sequencer: FILL -> (WASH -> RINSE) x N -> SPIN with a seconds prescaler.
// Define WASH_SIM_SPEEDUP_EN to replace the CLK_HZ time base with a 16-cycle second for simulation.
module wash_sequencer #(
   parameter int CLK_HZ     = 1_000_000,
   parameter int FILL_S     = 60,
   parameter int WASH_S     = 300,
   parameter int RINSE_S    = 120,
   parameter int SPIN_S     = 60,
   parameter int MAX_PASSES = 4,
   parameter int TIMER_W    = 9
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         clk_freq,
   input  logic               coin_in,
   input  logic [1:0]         passes,
   input  logic               timer_pause,
   output logic [2:0]         phase,
   output logic [1:0]         pass_idx,
   output logic [TIMER_W-1:0] sec_left,
   output logic               busy,
   output logic               wash_done
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      WASH  = 3'd2,
      RINSE = 3'd3,
      SPIN  = 3'd4
   } phase_t;

`ifdef WASH_SIM_SPEEDUP_EN
   localparam int PRE_W = 7;
   localparam int BASE  = 16;
`else
   localparam int PRE_W = $clog2(CLK_HZ * 8);
   localparam int BASE  = CLK_HZ;
`endif

   localparam logic [TIMER_W-1:0] FILL_T  = TIMER_W'(FILL_S);
   localparam logic [TIMER_W-1:0] WASH_T  = TIMER_W'(WASH_S);
   localparam logic [TIMER_W-1:0] RINSE_T = TIMER_W'(RINSE_S);
   localparam logic [TIMER_W-1:0] SPIN_T  = TIMER_W'(SPIN_S);
   localparam logic [1:0]         PASS_CAP = 2'(MAX_PASSES - 1);

   phase_t             phase_q, phase_d;
   logic [1:0]         pass_idx_q, pass_idx_d;
   logic [1:0]         pass_max_q, pass_max_d;
   logic [1:0]         freq_q, freq_d;
   logic [TIMER_W-1:0] sec_left_q, sec_left_d;
   logic [PRE_W-1:0]   pre_q, pre_d;
   logic               coin_prev_q, coin_prev_d;
   logic               busy_q, busy_d;
   logic               wash_done_q, wash_done_d;
   logic [PRE_W-1:0]   pre_term;
   logic               tick;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q     <= IDLE;
         pass_idx_q  <= 2'd0;
         pass_max_q  <= 2'd0;
         freq_q      <= 2'd0;
         sec_left_q  <= '0;
         pre_q       <= '0;
         coin_prev_q <= 1'b0;
         busy_q      <= 1'b0;
         wash_done_q <= 1'b0;
      end else begin
         phase_q     <= phase_d;
         pass_idx_q  <= pass_idx_d;
         pass_max_q  <= pass_max_d;
         freq_q      <= freq_d;
         sec_left_q  <= sec_left_d;
         pre_q       <= pre_d;
         coin_prev_q <= coin_prev_d;
         busy_q      <= busy_d;
         wash_done_q <= wash_done_d;
      end
   end

   always_comb begin
      phase_d     = phase_q;
      pass_idx_d  = pass_idx_q;
      pass_max_d  = pass_max_q;
      freq_d      = freq_q;
      sec_left_d  = sec_left_q;
      pre_d       = pre_q;
      wash_done_d = wash_done_q;
      coin_prev_d = coin_in;
      pre_term    = PRE_W'((BASE << freq_q) - 1);
      tick        = (pre_q == pre_term);

      if (phase_q == IDLE) begin
         pre_d = '0;
         if (coin_in && !coin_prev_q) begin
            freq_d      = clk_freq;
            pass_max_d  = (passes > PASS_CAP) ? PASS_CAP : passes;
            wash_done_d = 1'b0;
            phase_d     = FILL;
            sec_left_d  = FILL_T;
            pass_idx_d  = 2'd0;
         end
      end else if (phase_q == SPIN && timer_pause) begin
         // Paused spin: both the prescaler and the seconds count freeze.
         pre_d = pre_q;
      end else if (!tick) begin
         pre_d = pre_q + PRE_W'(1);
      end else begin
         pre_d = '0;
         if (sec_left_q != TIMER_W'(1)) begin
            sec_left_d = sec_left_q - TIMER_W'(1);
         end else begin
            case (phase_q)
               FILL: begin
                  phase_d    = WASH;
                  sec_left_d = WASH_T;
               end
               WASH: begin
                  phase_d    = RINSE;
                  sec_left_d = RINSE_T;
               end
               RINSE: begin
                  if (pass_idx_q < pass_max_q) begin
                     phase_d    = WASH;
                     sec_left_d = WASH_T;
                     pass_idx_d = pass_idx_q + 2'd1;
                  end else begin
                     phase_d    = SPIN;
                     sec_left_d = SPIN_T;
                  end
               end
               SPIN: begin
                  phase_d     = IDLE;
                  sec_left_d  = '0;
                  pass_idx_d  = 2'd0;
                  wash_done_d = 1'b1;
               end
               default: begin
                  phase_d    = IDLE;
                  sec_left_d = '0;
               end
            endcase
         end
      end

      busy_d = (phase_d != IDLE);
   end

   assign phase     = phase_q;
   assign pass_idx  = pass_idx_q;
   assign sec_left  = sec_left_q;
   assign busy      = busy_q;
   assign wash_done = wash_done_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed bench for wash_sequencer; CLK_HZ=16 gives a 16-cycle second in either build.
module tb_wash_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] clk_freq = 2'd0;
   logic       coin_in = 1'b0;
   logic [1:0] passes = 2'd0;
   logic       timer_pause = 1'b0;
   logic [2:0] phase;
   logic [1:0] pass_idx;
   logic [8:0] sec_left;
   logic       busy;
   logic       wash_done;

   int total = 0;
   int fails = 0;

   wash_sequencer #(.CLK_HZ(16)) dut (
      .clk(clk), .rst(rst), .clk_freq(clk_freq), .coin_in(coin_in),
      .passes(passes), .timer_pause(timer_pause), .phase(phase),
      .pass_idx(pass_idx), .sec_left(sec_left), .busy(busy), .wash_done(wash_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
         $display("check %-14s observed %0d expected %0d ok", tag, obs, exp);
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Counts negedges until phase reaches ph; returns -1 if the budget expires.
   task automatic wait_phase(input logic [2:0] ph, input int budget, output int n);
      n = 0;
      while (phase !== ph && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (phase !== ph) n = -1;
   endtask

   task automatic wait_sec(input logic [8:0] s, input int budget, output int n);
      n = 0;
      while (sec_left !== s && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (sec_left !== s) n = -1;
   endtask

   task automatic cycles(input int k);
      for (int i = 0; i < k; i++) @(negedge clk);
   endtask

   initial begin
      int n, n2, n3;

      // Reset state
      cycles(2);
      chk("rst_phase", phase, 0);
      chk("rst_sec", sec_left, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", wash_done, 0);
      rst = 1'b0;
      cycles(3);
      chk("idle_phase", phase, 0);

      // Single pass, 1x clock, with pause in WASH (ignored) and SPIN (honoured)
      clk_freq = 2'd0; passes = 2'd0;
      coin_in = 1'b1;
      @(negedge clk);
      coin_in = 1'b0;
      chk("a_fill", phase, 1);
      chk("a_fill_sec", sec_left, 60);
      chk("a_busy", busy, 1);
      wait_phase(3'd2, 1100, n);
      chk("a_fill_len", n, 960);
      timer_pause = 1'b1;
      cycles(500);
      timer_pause = 1'b0;
      wait_phase(3'd3, 5000, n);
      chk("a_wash_len", n + 500, 4800);
      chk("a_pass_idx", pass_idx, 0);
      wait_phase(3'd4, 2100, n);
      chk("a_rinse_len", n, 1920);
      wait_sec(9'd30, 600, n);
      chk("a_to_sec30", n, 480);
      timer_pause = 1'b1;
      cycles(500);
      chk("a_frozen", sec_left, 30);
      chk("a_still_spin", phase, 4);
      timer_pause = 1'b0;
      wait_phase(3'd0, 700, n2);
      chk("a_spin_len", n + 500 + n2, 1460);
      chk("a_done", wash_done, 1);
      chk("a_busy_end", busy, 0);
      chk("a_sec_end", sec_left, 0);

      // Double pass, 2x clock; inputs changed mid-run must not matter
      clk_freq = 2'd1; passes = 2'd1;
      coin_in = 1'b1;
      @(negedge clk);
      coin_in = 1'b0;
      chk("b_fill", phase, 1);
      chk("b_done_clr", wash_done, 0);
      wait_phase(3'd2, 2100, n);
      chk("b_fill_len", n, 1920);
      clk_freq = 2'd0; passes = 2'd0;
      wait_phase(3'd3, 9800, n);
      chk("b_wash0_len", n, 9600);
      chk("b_pass0", pass_idx, 0);
      coin_in = 1'b1;
      @(negedge clk);
      coin_in = 1'b0;
      @(negedge clk);
      chk("b_coin_ign", phase, 3);
      chk("b_busy", busy, 1);
      wait_phase(3'd2, 4000, n);
      chk("b_rinse0_len", n + 2, 3840);
      chk("b_pass1", pass_idx, 1);
      wait_phase(3'd3, 9800, n);
      chk("b_wash1_len", n, 9600);
      coin_in = 1'b1;
      wait_phase(3'd4, 4000, n);
      chk("b_rinse1_len", n, 3840);
      wait_phase(3'd0, 2100, n3);
      chk("b_spin_len", n3, 1920);
      chk("b_done", wash_done, 1);
      chk("b_pass_end", pass_idx, 0);

      // Coin held across completion: no restart; then a fresh edge restarts
      cycles(50);
      chk("c_no_restart", phase, 0);
      chk("c_done_held", wash_done, 1);
      coin_in = 1'b0;
      @(negedge clk);
      coin_in = 1'b1;
      @(negedge clk);
      coin_in = 1'b0;
      chk("c_restart", phase, 1);
      chk("c_done_clr", wash_done, 0);
      chk("c_sec", sec_left, 60);

      // Asynchronous reset during RINSE
      wait_phase(3'd2, 1100, n);
      chk("d_fill_len", n, 960);
      wait_phase(3'd3, 5000, n);
      chk("d_wash_len", n, 4800);
      cycles(100);
      #2 rst = 1'b1;
      #1;
      chk("d_rst_phase", phase, 0);
      chk("d_rst_sec", sec_left, 0);
      chk("d_rst_busy", busy, 0);
      chk("d_rst_pidx", pass_idx, 0);
      chk("d_rst_done", wash_done, 0);
      @(negedge clk);
      rst = 1'b0;
      cycles(2);
      coin_in = 1'b1;
      @(negedge clk);
      coin_in = 1'b0;
      chk("d_new_fill", phase, 1);
      chk("d_new_sec", sec_left, 60);
      cycles(16);
      chk("d_first_tick", sec_left, 59);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
